// File: rtl/rv32_regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_regfile_pkg : shared types, constants and parity helper for the     |
// |                    rv32_regfile_gen register file                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rv32_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dbg_state_t;

    localparam logic [7:0] AR_PAGE_DEFAULT = 8'h10;
    localparam int         NREG_E          = 16;
    localparam int         NREG_I          = 32;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_regfile_dbg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_regfile_dbg : debug access port, IDLE->ACCESS->RESP request FSM     |
// |                    with address decode and AR_DO / AR_ACK registers      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rv32_regfile_dbg
    import rv32_regfile_pkg::*;
#(
    parameter int         XLEN    = 32,
    parameter int         NREG    = NREG_I,
    parameter logic [7:0] AR_PAGE = AR_PAGE_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            i_ar_en,
    input  logic            i_ar_wr,
    input  logic [15:0]     i_ar_ad,
    input  logic [XLEN-1:0] i_ar_di,
    input  logic [XLEN-1:0] i_rd_data,
    output logic            o_wr_en,
    output logic [4:0]      o_wr_idx,
    output logic [XLEN-1:0] o_wr_data,
    output logic [4:0]      o_rd_idx,
    output logic            o_rd_hit,
    output logic [XLEN-1:0] o_ar_do,
    output logic            o_ar_ack
);

    localparam logic [7:0] c_nreg = 8'(NREG);

    dbg_state_t      r_state;
    dbg_state_t      w_next;
    logic            r_wr;
    logic [15:0]     r_ad;
    logic [XLEN-1:0] r_di;
    logic [XLEN-1:0] r_do;
    logic            r_ack;
    logic            w_hit;
    logic            w_access;

    // x0 and indices past the implemented file are misses on this page.
    assign w_hit = (r_ad[15:8] == AR_PAGE) && (r_ad[7:0] != 8'd0) && (r_ad[7:0] < c_nreg);

    always_comb begin
        w_next   = r_state;
        w_access = 1'b0;
        o_wr_en  = 1'b0;
        o_rd_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_ar_en) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                w_access = 1'b1;
                o_wr_en  = r_wr && w_hit;
                o_rd_hit = !r_wr && w_hit;
                w_next   = RESP;
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_ad    <= '0;
            r_di    <= '0;
            r_do    <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_access;
            if (r_state == IDLE && i_ar_en) begin
                r_wr <= i_ar_wr;
                r_ad <= i_ar_ad;
                r_di <= i_ar_di;
            end
            if (w_access && !r_wr) begin
                r_do <= w_hit ? i_rd_data : '0;
            end
        end
    end

    assign o_wr_idx  = r_ad[4:0];
    assign o_wr_data = r_di;
    assign o_rd_idx  = r_ad[4:0];
    assign o_ar_do   = r_do;
    assign o_ar_ack  = r_ack;

endmodule
`default_nettype wire

// File: rtl/rv32_regfile_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_regfile_gen : RV32I/RV32E integer register file, two registered     |
// |                    read ports with bypass, debug port, optional parity   |
// |                    (define RV32_REGFILE_PARITY_EN to add parity + PERR)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rv32_regfile_gen
    import rv32_regfile_pkg::*;
#(
    parameter int         XLEN    = 32,
    parameter int         NREG    = NREG_I,
    parameter logic [7:0] AR_PAGE = AR_PAGE_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            WE,
    input  logic [4:0]      WADDR,
    input  logic [XLEN-1:0] WDATA,
    input  logic            RE,
    input  logic [4:0]      RS1ADDR,
    output logic [XLEN-1:0] RS1,
    input  logic [4:0]      RS2ADDR,
    output logic [XLEN-1:0] RS2,
    output logic            ILLEGAL,
    input  logic            AR_EN,
    input  logic            AR_WR,
    input  logic [15:0]     AR_AD,
    input  logic [XLEN-1:0] AR_DI,
    output logic [XLEN-1:0] AR_DO,
    output logic            AR_ACK
`ifdef RV32_REGFILE_PARITY_EN
    ,
    output logic            PERR
`endif
);

    localparam logic [5:0] c_nreg = 6'(NREG);

    logic [XLEN-1:0] w_rf [32];
    logic            w_dbg_we;
    logic [4:0]      w_dbg_widx;
    logic [XLEN-1:0] w_dbg_wdata;
    logic [4:0]      w_dbg_ridx;
    logic            w_dbg_rhit;
    logic            w_wr_ok;
    logic            w_rs1_ok;
    logic            w_rs2_ok;
    logic            w_byp1;
    logic            w_byp2;
    logic            w_illegal;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic            r_illegal;
`ifdef RV32_REGFILE_PARITY_EN
    logic            w_par [32];
`endif

    assign w_wr_ok  = (WADDR   != 5'd0) && ({1'b0, WADDR}   < c_nreg);
    assign w_rs1_ok = (RS1ADDR != 5'd0) && ({1'b0, RS1ADDR} < c_nreg);
    assign w_rs2_ok = (RS2ADDR != 5'd0) && ({1'b0, RS2ADDR} < c_nreg);
    assign w_byp1   = WE && w_wr_ok && (WADDR == RS1ADDR);
    assign w_byp2   = WE && w_wr_ok && (WADDR == RS2ADDR);

    assign w_illegal = (WE && ({1'b0, WADDR}   >= c_nreg)) ||
                       (RE && ({1'b0, RS1ADDR} >= c_nreg)) ||
                       (RE && ({1'b0, RS2ADDR} >= c_nreg));

    // Only entries 1..NREG-1 get storage; debug writes take priority over the core.
    for (genvar i = 0; i < 32; i++) begin : g_reg
        if (i > 0 && i < NREG) begin : g_live
            logic [XLEN-1:0] r_q;
            logic            w_dbg_hit;
            logic            w_core_hit;
            assign w_dbg_hit  = w_dbg_we && (w_dbg_widx == 5'(i));
            assign w_core_hit = WE && (WADDR == 5'(i));
`ifdef RV32_REGFILE_PARITY_EN
            logic r_p;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_p <= 1'b0;
                end else if (w_dbg_hit) begin
                    r_p <= even_parity(64'(w_dbg_wdata));
                end else if (w_core_hit) begin
                    r_p <= even_parity(64'(WDATA));
                end
            end
            assign w_par[i] = r_p;
`endif
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_q <= '0;
                end else if (w_dbg_hit) begin
                    r_q <= w_dbg_wdata;
                end else if (w_core_hit) begin
                    r_q <= WDATA;
                end
            end
            assign w_rf[i] = r_q;
        end else begin : g_zero
            assign w_rf[i] = '0;
`ifdef RV32_REGFILE_PARITY_EN
            assign w_par[i] = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_illegal;
            if (RE) begin
                if (!w_rs1_ok) begin
                    r_rs1 <= '0;
                end else if (w_byp1) begin
                    r_rs1 <= WDATA;
                end else begin
                    r_rs1 <= w_rf[RS1ADDR];
                end
                if (!w_rs2_ok) begin
                    r_rs2 <= '0;
                end else if (w_byp2) begin
                    r_rs2 <= WDATA;
                end else begin
                    r_rs2 <= w_rf[RS2ADDR];
                end
            end
        end
    end

    rv32_regfile_dbg #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .AR_PAGE (AR_PAGE)
    ) u_dbg (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_ar_en   (AR_EN),
        .i_ar_wr   (AR_WR),
        .i_ar_ad   (AR_AD),
        .i_ar_di   (AR_DI),
        .i_rd_data (w_rf[w_dbg_ridx]),
        .o_wr_en   (w_dbg_we),
        .o_wr_idx  (w_dbg_widx),
        .o_wr_data (w_dbg_wdata),
        .o_rd_idx  (w_dbg_ridx),
        .o_rd_hit  (w_dbg_rhit),
        .o_ar_do   (AR_DO),
        .o_ar_ack  (AR_ACK)
    );

`ifdef RV32_REGFILE_PARITY_EN
    logic w_perr_now;
    logic r_perr;

    // Bypassed reads never touched storage, so only stored values are checked.
    assign w_perr_now =
        (RE && w_rs1_ok && !w_byp1 && (even_parity(64'(w_rf[RS1ADDR])) != w_par[RS1ADDR])) ||
        (RE && w_rs2_ok && !w_byp2 && (even_parity(64'(w_rf[RS2ADDR])) != w_par[RS2ADDR])) ||
        (w_dbg_rhit && (even_parity(64'(w_rf[w_dbg_ridx])) != w_par[w_dbg_ridx]));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_perr <= 1'b0;
        end else if (w_perr_now) begin
            r_perr <= 1'b1;
        end
    end

    assign PERR = r_perr;
`endif

    assign RS1     = r_rs1;
    assign RS2     = r_rs2;
    assign ILLEGAL = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv32_regfile_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv32_regfile_gen : directed scoreboard bench for rv32_regfile_gen     |
// |                       (RV32E configuration, NREG=16)                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rv32_regfile_gen;

    localparam int c_sel_rs1 = 0;
    localparam int c_sel_rs2 = 1;
    localparam int c_sel_ill = 2;
    localparam int c_sel_do  = 3;
    localparam int c_sel_ack = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        WE;
    logic [4:0]  WADDR;
    logic [31:0] WDATA;
    logic        RE;
    logic [4:0]  RS1ADDR;
    logic [31:0] RS1;
    logic [4:0]  RS2ADDR;
    logic [31:0] RS2;
    logic        ILLEGAL;
    logic        AR_EN;
    logic        AR_WR;
    logic [15:0] AR_AD;
    logic [31:0] AR_DI;
    logic [31:0] AR_DO;
    logic        AR_ACK;
`ifdef RV32_REGFILE_PARITY_EN
    logic        PERR;
`endif

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    rv32_regfile_gen #(
        .XLEN    (32),
        .NREG    (16),
        .AR_PAGE (8'h10)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .WE      (WE),
        .WADDR   (WADDR),
        .WDATA   (WDATA),
        .RE      (RE),
        .RS1ADDR (RS1ADDR),
        .RS1     (RS1),
        .RS2ADDR (RS2ADDR),
        .RS2     (RS2),
        .ILLEGAL (ILLEGAL),
        .AR_EN   (AR_EN),
        .AR_WR   (AR_WR),
        .AR_AD   (AR_AD),
        .AR_DI   (AR_DI),
        .AR_DO   (AR_DO),
        .AR_ACK  (AR_ACK)
`ifdef RV32_REGFILE_PARITY_EN
        ,
        .PERR    (PERR)
`endif
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            c_sel_rs1: return RS1;
            c_sel_rs2: return RS2;
            c_sel_ill: return {31'd0, ILLEGAL};
            c_sel_do:  return AR_DO;
            c_sel_ack: return {31'd0, AR_ACK};
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        check_now();
    endtask

    task automatic dbg_op(input logic wr, input logic [15:0] ad, input logic [31:0] di,
                          input logic [31:0] exp_do);
        AR_EN = 1'b1;
        AR_WR = wr;
        AR_AD = ad;
        AR_DI = di;
        push("ack_access", c_sel_ack, 32'd0);
        tick();
        AR_EN = 1'b0;
        push("ack_resp", c_sel_ack, 32'd1);
        push("ar_do", c_sel_do, exp_do);
        tick();
        push("ack_idle", c_sel_ack, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b1; WE = 1'b0; WADDR = '0; WDATA = '0; RE = 1'b0;
        RS1ADDR = '0; RS2ADDR = '0; AR_EN = 1'b0; AR_WR = 1'b0; AR_AD = '0; AR_DI = '0;
        #2 RST_N = 1'b0;
        #1;
        push("rst_rs1", c_sel_rs1, 32'd0);
        push("rst_rs2", c_sel_rs2, 32'd0);
        push("rst_do",  c_sel_do,  32'd0);
        push("rst_ack", c_sel_ack, 32'd0);
        push("rst_ill", c_sel_ill, 32'd0);
        check_now();
        @(posedge CLK);
        #1 RST_N = 1'b1;

        // Basic write then read, x0 on port 2
        WE = 1'b1; WADDR = 5'd5; WDATA = 32'hDEADBEEF;
        tick();
        WE = 1'b0; RE = 1'b1; RS1ADDR = 5'd5; RS2ADDR = 5'd0;
        push("rd_x5", c_sel_rs1, 32'hDEADBEEF);
        push("rd_x0", c_sel_rs2, 32'd0);
        tick();

        // Same-cycle bypass, then RE=0 hold
        WE = 1'b1; WADDR = 5'd7; WDATA = 32'h12345678; RS1ADDR = 5'd7; RS2ADDR = 5'd5;
        push("bypass_x7", c_sel_rs1, 32'h12345678);
        push("rs2_x5", c_sel_rs2, 32'hDEADBEEF);
        push("ill_none", c_sel_ill, 32'd0);
        tick();
        WE = 1'b0; RE = 1'b0; RS1ADDR = 5'd5; RS2ADDR = 5'd20;
        push("hold_rs1", c_sel_rs1, 32'h12345678);
        push("hold_rs2", c_sel_rs2, 32'hDEADBEEF);
        push("ill_re0", c_sel_ill, 32'd0);
        tick();

        // Illegal indices and NREG boundary
        WE = 1'b1; WADDR = 5'd20; WDATA = 32'hFFFFFFFF; RE = 1'b1; RS1ADDR = 5'd7; RS2ADDR = 5'd17;
        push("ill_wr20", c_sel_ill, 32'd1);
        push("stored_x7", c_sel_rs1, 32'h12345678);
        push("rs2_ill17", c_sel_rs2, 32'd0);
        tick();
        WE = 1'b0; RS1ADDR = 5'd4; RS2ADDR = 5'd15;
        push("ill_pulse_end", c_sel_ill, 32'd0);
        push("x4_untouched", c_sel_rs1, 32'd0);
        push("x15_zero", c_sel_rs2, 32'd0);
        tick();
        WE = 1'b1; WADDR = 5'd15; WDATA = 32'h0F0F0F0F; RS1ADDR = 5'd0; RS2ADDR = 5'd16;
        push("ill_rd16", c_sel_ill, 32'd1);
        push("rs2_ill16", c_sel_rs2, 32'd0);
        tick();
        WE = 1'b1; WADDR = 5'd16; WDATA = 32'hCAFEF00D; RS1ADDR = 5'd15; RS2ADDR = 5'd0;
        push("ill_wr16", c_sel_ill, 32'd1);
        push("x15_stored", c_sel_rs1, 32'h0F0F0F0F);
        tick();
        WE = 1'b1; WADDR = 5'd0; WDATA = 32'h00001234; RS1ADDR = 5'd0;
        push("x0_wr_no_ill", c_sel_ill, 32'd0);
        push("x0_no_bypass", c_sel_rs1, 32'd0);
        tick();
        WE = 1'b0; RE = 1'b0;

        // Debug write, reads hit/miss, AR_DO hold on write
        dbg_op(1'b1, 16'h1003, 32'hA5A5A5A5, 32'd0);
        RE = 1'b1; RS1ADDR = 5'd3; RS2ADDR = 5'd9;
        push("core_x3_dbgwr", c_sel_rs1, 32'hA5A5A5A5);
        dbg_op(1'b0, 16'h1003, 32'd0, 32'hA5A5A5A5);
        RE = 1'b0;
        dbg_op(1'b0, 16'h2003, 32'd0, 32'd0);
        dbg_op(1'b0, 16'h1007, 32'd0, 32'h12345678);
        dbg_op(1'b1, 16'h1010, 32'h55555555, 32'h12345678);
        dbg_op(1'b0, 16'h1010, 32'd0, 32'd0);
        dbg_op(1'b0, 16'h100F, 32'd0, 32'h0F0F0F0F);

        // Collision in ACCESS, AR_EN during RESP ignored
        AR_EN = 1'b1; AR_WR = 1'b1; AR_AD = 16'h1009; AR_DI = 32'd1;
        push("col_ack_access", c_sel_ack, 32'd0);
        tick();
        AR_EN = 1'b0; WE = 1'b1; WADDR = 5'd9; WDATA = 32'd2;
        push("col_ack_resp", c_sel_ack, 32'd1);
        tick();
        WE = 1'b0; AR_EN = 1'b1; AR_WR = 1'b0;
        push("col_ack_idle", c_sel_ack, 32'd0);
        tick();
        AR_EN = 1'b0; RE = 1'b1; RS1ADDR = 5'd9;
        push("resp_en_ignored1", c_sel_ack, 32'd0);
        push("col_dbg_wins", c_sel_rs1, 32'd1);
        tick();
        push("resp_en_ignored2", c_sel_ack, 32'd0);
        tick();
        dbg_op(1'b0, 16'h1009, 32'd0, 32'd1);

        // Reset in the middle of ACCESS
        AR_EN = 1'b1; AR_WR = 1'b1; AR_AD = 16'h1005; AR_DI = 32'h77;
        push("pre_rst_rs1", c_sel_rs1, 32'd1);
        push("pre_rst_ack", c_sel_ack, 32'd0);
        tick();
        AR_EN = 1'b0;
        RST_N = 1'b0;
        #1;
        push("async_rst_rs1", c_sel_rs1, 32'd0);
        push("async_rst_do", c_sel_do, 32'd0);
        push("async_rst_ack", c_sel_ack, 32'd0);
        check_now();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        push("dropped_ack1", c_sel_ack, 32'd0);
        tick();
        push("dropped_ack2", c_sel_ack, 32'd0);
        push("x9_cleared", c_sel_rs1, 32'd0);
        tick();
        RS1ADDR = 5'd5;
        push("dropped_ack3", c_sel_ack, 32'd0);
        push("x5_not_written", c_sel_rs1, 32'd0);
        tick();

`ifdef RV32_REGFILE_PARITY_EN
        checks++;
        assert (PERR === 1'b0) else begin
            errors++;
            $error("FAIL perr_clean observed=%b expected=0", PERR);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
